// File: rtl/subtractor_8bits_serial.sv
`default_nettype none
// ============================================================================
// Module   : subtractor_8bits_serial
// Brief    : Bit-serial 8-bit unsigned subtractor (LSB first), one bit per
//            clock, with done pulse and enable-gated result/borrow outputs.
// Revision : 1.0 - initial release
// ============================================================================
module subtractor_8bits_serial (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [7:0] a,
    input  logic [7:0] b,
    input  logic       en,
    output logic [7:0] t,
    output logic       flag,
    output logic       busy,
    output logic       done
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [2:0] c_last_bit = 3'd7;

    state_t     r_state;
    state_t     w_state_next;
    logic [7:0] r_opa;
    logic [7:0] r_opb;
    logic [7:0] r_result;
    logic       r_borrow;
    logic [2:0] r_cnt;

    logic       w_ai;
    logic       w_bi;
    logic       w_d;
    logic       w_br_next;

    // Full-subtractor on the bit currently selected by the counter.
    assign w_ai      = r_opa[r_cnt];
    assign w_bi      = r_opb[r_cnt];
    assign w_d       = w_ai ^ w_bi ^ r_borrow;
    assign w_br_next = (~w_ai & w_bi) | (~(w_ai ^ w_bi) & r_borrow);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE:    if (start) w_state_next = RUN;
            RUN:     if (r_cnt == c_last_bit) w_state_next = DONE;
            DONE:    w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_opa    <= 8'h00;
            r_opb    <= 8'h00;
            r_result <= 8'h00;
            r_borrow <= 1'b0;
            r_cnt    <= 3'd0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_opa    <= a;
                        r_opb    <= b;
                        r_borrow <= 1'b0;
                        r_cnt    <= 3'd0;
                    end
                end
                RUN: begin
                    // Difference bits enter at the MSB so bit i lands at index i after 8 shifts.
                    r_result <= {w_d, r_result[7:1]};
                    r_borrow <= w_br_next;
                    r_cnt    <= r_cnt + 3'd1;
                end
                default: begin
                end
            endcase
        end
    end

    assign busy = (r_state == RUN);
    assign done = (r_state == DONE);
    assign t    = en ? r_result : 8'h00;
    assign flag = en ? r_borrow : 1'b0;

endmodule
`default_nettype wire

// File: tb/tb_subtractor_8bits_serial.sv
`default_nettype none
// ============================================================================
// Module   : tb_subtractor_8bits_serial
// Brief    : Self-checking bench: directed cases plus random back-to-back
//            operations compared against an arithmetic reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_subtractor_8bits_serial;

    logic       clk;
    logic       rst;
    logic       start;
    logic [7:0] a;
    logic [7:0] b;
    logic       en;
    logic [7:0] t;
    logic       flag;
    logic       busy;
    logic       done;

    int passed;
    int total;

    subtractor_8bits_serial dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .a     (a),
        .b     (b),
        .en    (en),
        .t     (t),
        .flag  (flag),
        .busy  (busy),
        .done  (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // Reference: plain modular arithmetic and unsigned comparison.
    function automatic logic [7:0] ref_diff(input logic [7:0] x, input logic [7:0] y);
        int d;
        d = (int'(x) - int'(y) + 256) % 256;
        return d[7:0];
    endfunction

    function automatic logic ref_flag(input logic [7:0] x, input logic [7:0] y);
        return (x < y);
    endfunction

    // Launch one subtraction from IDLE, wait (bounded) for done, check result,
    // then advance one cycle so the block is back in IDLE.
    task automatic do_op(input string tag, input logic [7:0] x, input logic [7:0] y);
        int  nbusy;
        int  lat;
        bit  found;
        a     = x;
        b     = y;
        start = 1'b1;
        step();
        start = 1'b0;
        nbusy = 0;
        lat   = 0;
        found = 1'b0;
        for (int j = 0; j < 20 && !found; j++) begin
            if (done) begin
                found = 1'b1;
                lat   = j;
            end else begin
                if (busy) nbusy++;
                step();
            end
        end
        chk({tag, "_done_seen"}, found, 1);
        chk({tag, "_latency"}, lat, 8);
        chk({tag, "_busy_cycles"}, nbusy, 8);
        chk({tag, "_t"}, t, ref_diff(x, y));
        chk({tag, "_flag"}, flag, ref_flag(x, y));
        step();
        chk({tag, "_done_single"}, {busy, done}, 2'b00);
        chk({tag, "_t_hold"}, t, ref_diff(x, y));
    endtask

    initial begin
        int ndone;
        logic [7:0] rx;
        logic [7:0] ry;
        passed = 0;
        total  = 0;
        rst    = 1'b1;
        start  = 1'b1;
        a      = 8'hAA;
        b      = 8'h55;
        en     = 1'b1;

        // Reset with start held high: start must be ignored.
        step();
        step();
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_t", t, 8'h00);
        chk("rst_flag", flag, 0);
        rst   = 1'b0;
        start = 1'b0;
        step();
        chk("post_rst_idle", {busy, done}, 2'b00);

        do_op("s100_37", 8'd100, 8'd37);
        chk("s100_37_const", t, 8'h3F);
        do_op("s37_100", 8'd37, 8'd100);
        chk("s37_100_const", {flag, t}, {1'b1, 8'hC1});

        en = 1'b0;
        #1;
        chk("en0_t", t, 8'h00);
        chk("en0_flag", flag, 0);
        en = 1'b1;
        #1;
        chk("en1_t", t, 8'hC1);
        chk("en1_flag", flag, 1);

        do_op("s0_1", 8'd0, 8'd1);
        chk("s0_1_const", {flag, t}, {1'b1, 8'hFF});
        do_op("s255_255", 8'd255, 8'd255);
        chk("s255_255_const", {flag, t}, {1'b0, 8'h00});

        // Second start and operand change during RUN must be ignored.
        a     = 8'd200;
        b     = 8'd55;
        start = 1'b1;
        step();
        start = 1'b0;
        step();
        step();
        a     = 8'd1;
        b     = 8'd2;
        start = 1'b1;
        step();
        start = 1'b0;
        ndone = 0;
        for (int j = 0; j < 20; j++) begin
            if (done) begin
                ndone++;
                chk("ignore_t", t, 8'h91);
                chk("ignore_flag", flag, 0);
            end
            step();
        end
        chk("ignore_ndone", ndone, 1);

        // Reset mid-operation discards the operation.
        a     = 8'd10;
        b     = 8'd20;
        start = 1'b1;
        step();
        start = 1'b0;
        step();
        step();
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("midrst_busy", busy, 0);
        chk("midrst_done", done, 0);
        chk("midrst_t", t, 8'h00);
        chk("midrst_flag", flag, 0);
        ndone = 0;
        for (int j = 0; j < 12; j++) begin
            if (done || busy) ndone++;
            step();
        end
        chk("midrst_quiet", ndone, 0);
        do_op("s10_20", 8'd10, 8'd20);
        chk("s10_20_const", {flag, t}, {1'b1, 8'hF6});

        // Random back-to-back operations.
        for (int n = 0; n < 40; n++) begin
            rx = 8'($urandom_range(0, 255));
            ry = 8'($urandom_range(0, 255));
            do_op("rand", rx, ry);
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
`default_nettype wire
